// File: rtl/blue_pkg.sv
// -----------------------------------------------------------------------------
// blue_pkg
// Shared definitions for the blue instruction sequencer: the default program
// counter width, the fetch/execute state encoding and the control-flow opcodes
// decoded from IR[15:12]. Any opcode not listed here is a datapath instruction.
// -----------------------------------------------------------------------------
package blue_pkg;

  localparam int ADDR_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [3:0] OP_JMP = 4'hF;
  localparam logic [3:0] OP_JZ  = 4'hE;
  localparam logic [3:0] OP_JN  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hB;

endpackage

// File: rtl/blue_pc.sv
// -----------------------------------------------------------------------------
// blue_pc
// Program counter register. Load of a branch target takes priority over
// increment; the increment wraps modulo 2^ADDR_W.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset, clears PC to 0
//   inc_i     in   advance PC by one
//   load_i    in   load target_i (wins over inc_i)
//   target_i  in   branch / jump target
//   pc_o      out  current program counter
// -----------------------------------------------------------------------------
module blue_pc
  import blue_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/blue_seq.sv
// -----------------------------------------------------------------------------
// blue_seq
// Instruction sequencer feeding the blue datapath. Fetches 16-bit words over a
// req/ack handshake, resolves jumps, flag-conditional branches and halt
// locally, and hands every other word to the datapath with a one-cycle en.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   mem_addr  out  fetch address (the PC)
//   mem_req   out  fetch request, high throughout FETCH
//   mem_ack   in   mem_data valid this cycle (ignored outside FETCH)
//   mem_data  in   instruction word
//   znc_in    in   datapath flags [2] zero, [1] negative, [0] carry
//   opCode    out  instruction register, to the datapath
//   en        out  one-cycle datapath enable per datapath instruction
//   halted    out  high while halted
// -----------------------------------------------------------------------------
module blue_seq
  import blue_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  input  logic [2:0]        znc_in,
  output logic [15:0]       opCode,
  output logic              en,
  output logic              halted
);

  state_e            state_q;
  state_e            state_d;
  logic [15:0]       ir_q;
  logic [15:0]       ir_d;
  logic              pc_inc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        op;
  logic [ADDR_W-1:0] target;

  assign op     = ir_q[15:12];
  assign target = ir_q[ADDR_W-1:0];

  blue_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (pc_inc),
    .load_i   (pc_load),
    .target_i (target),
    .pc_o     (pc)
  );

  // Next-state, IR load and outputs. mem_req, en and halted depend only on
  // the state register (and IR in EXEC), so they fall with rst asynchronously.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    mem_req = 1'b0;
    en      = 1'b0;
    halted  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_d    = mem_data;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op)
          OP_JMP: pc_load = 1'b1;
          OP_JZ:  begin pc_load = znc_in[2]; pc_inc = ~znc_in[2]; end
          OP_JN:  begin pc_load = znc_in[1]; pc_inc = ~znc_in[1]; end
          OP_JC:  begin pc_load = znc_in[0]; pc_inc = ~znc_in[0]; end
          OP_HLT: state_d = ST_HALT;  // PC left pointing at the HLT word
          default: begin
            en     = 1'b1;
            pc_inc = 1'b1;
          end
        endcase
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign mem_addr = pc;
  assign opCode   = ir_q;

endmodule

// File: tb/tb_blue_seq.sv
// -----------------------------------------------------------------------------
// tb_blue_seq
// Directed bench for blue_seq. A behavioural program memory acks each request
// after a configurable number of wait cycles; outputs are sampled on the
// falling edge, half a cycle away from the active edge.
// -----------------------------------------------------------------------------
module tb_blue_seq;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack = 1'b0;
  logic [15:0]       mem_data = 16'h0000;
  logic [2:0]        znc_in = 3'b000;
  logic [15:0]       opCode;
  logic              en;
  logic              halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:(1<<ADDR_W)-1];
  int          wait_cfg = 0;
  int          wait_cnt = 0;

  blue_seq #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .znc_in   (znc_in),
    .opCode   (opCode),
    .en       (en),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Program memory: acks after wait_cfg request cycles, data valid with ack.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt >= wait_cfg) begin
        mem_ack  = 1'b1;
        mem_data = mem[mem_addr];
      end else begin
        mem_ack  = 1'b0;
        mem_data = 16'hDEAD;
      end
      wait_cnt = wait_cnt + 1;
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0000;
  endtask

  // Reset for two cycles, released on a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (opCode !== 16'h0000 || en !== 1'b0 || mem_req !== 1'b0 ||
        halted !== 1'b0 || mem_addr !== 12'h000) begin
      errors++;
      $display("FAIL reset_values: opCode=%h en=%b req=%b halted=%b addr=%h, need 0000 0 0 0 000",
               opCode, en, mem_req, halted, mem_addr);
    end
  endtask

  task automatic test_zero_wait();
    clear_mem();
    mem[0]   = 16'h1234;
    wait_cfg = 0;
    do_reset();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h000 || en !== 1'b0) begin
      errors++;
      $display("FAIL zw_fetch: req=%b addr=%h en=%b, need 1 000 0", mem_req, mem_addr, en);
    end
    @(negedge clk);
    checks++;
    if (en !== 1'b1 || opCode !== 16'h1234 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL zw_exec: en=%b opCode=%h req=%b, need 1 1234 0", en, opCode, mem_req);
    end
    @(negedge clk);
    checks++;
    if (en !== 1'b0 || mem_addr !== 12'h001 || mem_req !== 1'b1 || opCode !== 16'h1234) begin
      errors++;
      $display("FAIL zw_next: en=%b addr=%h req=%b opCode=%h, need 0 001 1 1234",
               en, mem_addr, mem_req, opCode);
    end
  endtask

  task automatic test_wait_states();
    clear_mem();
    mem[0]   = 16'h0042;
    wait_cfg = 3;
    do_reset();
    // Three wait cycles plus the ack cycle, all in FETCH.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 12'h000 || en !== 1'b0) begin
        errors++;
        $display("FAIL ws_wait%0d: req=%b addr=%h en=%b, need 1 000 0", c, mem_req, mem_addr, en);
      end
    end
    @(negedge clk);
    checks++;
    if (en !== 1'b1 || opCode !== 16'h0042) begin
      errors++;
      $display("FAIL ws_exec: en=%b opCode=%h, need 1 0042", en, opCode);
    end
    @(negedge clk);
    checks++;
    if (en !== 1'b0 || mem_addr !== 12'h001) begin
      errors++;
      $display("FAIL ws_after: en=%b addr=%h, need 0 001", en, mem_addr);
    end
    wait_cfg = 0;
  endtask

  // Single control-flow word at 0 with zero-wait memory; checks no en in
  // EXEC and the address of the following fetch.
  task automatic run_ctrl(input string name, input logic [15:0] word,
                          input logic [2:0] znc, input logic [11:0] exp_next);
    clear_mem();
    mem[0]   = word;
    znc_in   = znc;
    wait_cfg = 0;
    do_reset();
    @(negedge clk);  // FETCH at 0
    @(negedge clk);  // EXEC
    checks++;
    if (en !== 1'b0 || opCode !== word) begin
      errors++;
      $display("FAIL %s_exec: en=%b opCode=%h, need 0 %h", name, en, opCode, word);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== exp_next) begin
      errors++;
      $display("FAIL %s_next: req=%b addr=%h, need 1 %h", name, mem_req, mem_addr, exp_next);
    end
  endtask

  task automatic test_branches();
    run_ctrl("jmp",       16'hF0A5, 3'b000, 12'h0A5);
    run_ctrl("jz_taken",  16'hE010, 3'b100, 12'h010);
    run_ctrl("jz_not",    16'hE010, 3'b000, 12'h001);
    run_ctrl("jz_other",  16'hE010, 3'b011, 12'h001);
    run_ctrl("jn_taken",  16'hD020, 3'b010, 12'h020);
    run_ctrl("jn_not",    16'hD020, 3'b101, 12'h001);
    run_ctrl("jc_taken",  16'hC030, 3'b001, 12'h030);
    run_ctrl("jc_not",    16'hC030, 3'b110, 12'h001);
    znc_in = 3'b000;
  endtask

  task automatic test_halt();
    int en_count;
    int budget;
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = 16'h0100 + 16'(i);
    mem[5]   = 16'hB000;
    wait_cfg = 0;
    do_reset();
    en_count = 0;
    budget   = 0;
    while (halted !== 1'b1 && budget < 40) begin
      @(negedge clk);
      if (en === 1'b1) en_count++;
      budget++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_reached: halted=%b after %0d cycles, need 1", halted, budget);
    end
    checks++;
    if (en_count != 5 || mem_addr !== 12'h005) begin
      errors++;
      $display("FAIL halt_progress: en_pulses=%0d addr=%h, need 5 005", en_count, mem_addr);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || en !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold%0d: halted=%b req=%b en=%b, need 1 0 0", c, halted, mem_req, en);
      end
    end
    mem[0] = 16'h0777;
    do_reset();
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 12'h000) begin
      errors++;
      $display("FAIL halt_restart: halted=%b req=%b addr=%h, need 0 1 000", halted, mem_req, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (en !== 1'b1 || opCode !== 16'h0777) begin
      errors++;
      $display("FAIL halt_refetch: en=%b opCode=%h, need 1 0777", en, opCode);
    end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0]     = 16'hFFFF;  // JMP 0xFFF
    mem[12'hFFF] = 16'h1111;
    wait_cfg   = 0;
    do_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (mem_addr !== 12'hFFF || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL wrap_jump: addr=%h req=%b, need FFF 1", mem_addr, mem_req);
    end
    @(negedge clk);
    checks++;
    if (en !== 1'b1 || opCode !== 16'h1111) begin
      errors++;
      $display("FAIL wrap_exec: en=%b opCode=%h, need 1 1111", en, opCode);
    end
    @(negedge clk);
    checks++;
    if (mem_addr !== 12'h000 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL wrap_next: addr=%h req=%b, need 000 1", mem_addr, mem_req);
    end
  endtask

  task automatic test_reset_mid_wait();
    clear_mem();
    mem[0]   = 16'hF010;
    wait_cfg = 2;
    do_reset();
    repeat (5) @(negedge clk);  // FETCH x3, EXEC, first wait cycle at 0x010
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h010) begin
      errors++;
      $display("FAIL rw_waiting: req=%b addr=%h, need 1 010", mem_req, mem_addr);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 12'h000 || opCode !== 16'h0000) begin
      errors++;
      $display("FAIL rw_async: req=%b addr=%h opCode=%h, need 0 000 0000", mem_req, mem_addr, opCode);
    end
    wait_cfg = 0;
    mem[0]   = 16'h0055;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h000) begin
      errors++;
      $display("FAIL rw_restart: req=%b addr=%h, need 1 000", mem_req, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (en !== 1'b1 || opCode !== 16'h0055) begin
      errors++;
      $display("FAIL rw_exec: en=%b opCode=%h, need 1 0055", en, opCode);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branches();
    test_halt();
    test_wrap();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blue_seq.md
# blue_seq

Instruction sequencer that sits directly upstream of the `blue` datapath. It fetches 16-bit instruction words from program memory over a req/ack handshake, resolves control-flow instructions (jumps, flag-conditional branches, halt) locally using the datapath's `znc` flags, and presents every other word to the datapath as `opCode` with a one-cycle `en` strobe. It owns the program counter and the fetch/execute state machine.

## Interface
- `ADDR_W`, 12, program counter and memory address width; equals the jump-target field width.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_addr`  out  ADDR_W  fetch address (= PC).
- `mem_req`  out  1  fetch request.
- `mem_ack`  in  1  memory has valid `mem_data` this cycle.
- `mem_data`  in  16  instruction word.
- `znc_in`  in  3  datapath flags: [2] zero, [1] negative, [0] carry.
- `opCode`  out  16  instruction register, to datapath.
- `en`  out  1  datapath register enable, one-cycle pulse per datapath instruction.
- `halted`  out  1  high while in HALT.

## Operation
- Decode on `IR[15:12]`: `4'hF` JMP, `4'hE` JZ (taken if znc_in[2]), `4'hD` JN (znc_in[1]), `4'hC` JC (znc_in[0]), `4'hB` HLT; every other value is a datapath instruction. Branch target = `IR[ADDR_W-1:0]`.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: reset state; unconditionally -> FETCH on next edge.
- FETCH: `mem_req`=1, `mem_addr`=PC; on an edge with `mem_ack`=1, IR <= `mem_data`, -> EXEC; otherwise hold, address stable.
- EXEC (exactly one cycle): datapath instruction -> `en`=1, PC <= PC+1. JMP or taken branch -> PC <= target. Untaken branch -> PC <= PC+1. All three -> FETCH. HLT -> PC unchanged, -> HALT.
- HALT: absorbing; exited only by `rst`. `en`=0, `mem_req`=0.
- Control-flow instructions never assert `en`; datapath A/B/znc unaffected.
- PC arithmetic modulo 2^ADDR_W: PC=`12'hFFF` + 1 -> `12'h000`.
- `mem_ack` outside FETCH is ignored.

## Timing
- Reset values: PC=0, IR=`16'h0000` (so `opCode`=0), `en`=0, `mem_req`=0, `halted`=0, state IDLE. `mem_req`, `en`, `halted` decoded combinationally from state, so they drop asynchronously with `rst`.
- `mem_ack` may be high in the first FETCH cycle (zero wait) -> minimum 2 cycles per instruction (FETCH, EXEC); each wait cycle adds one.
- `opCode` is valid from the edge entering EXEC and held until the next IR load; datapath captures on the edge ending EXEC.
- Flags: datapath znc updates on the edge ending EXEC; the next branch samples `znc_in` in its own EXEC, at least 2 cycles later, so always sees the preceding datapath instruction's flags. No forwarding or stall required.
- `rst` during a FETCH wait: request drops immediately; restart at PC=0 after IDLE.

## Structure
- Package `blue_pkg`: state encoding constants, opcode constants (`OP_JMP`, `OP_JZ`, `OP_JN`, `OP_JC`, `OP_HLT`), `ADDR_W` default.
- One sub-module, `blue_pc`: ADDR_W-bit register with async reset, increment, and load-target inputs (load has priority over increment).
- FSM, IR and decode in `blue_seq`.

## Test plan
- Reset then zero-wait memory with word `16'h1234` at 0: `mem_req` high first cycle after IDLE, `opCode`=`16'h1234`, `en` one cycle, `mem_addr` then 1.
- Memory acks after 3 wait cycles: `mem_addr` stable, `en` low throughout wait, single `en` pulse after.
- `16'hF0A5` at 0: no `en`, next `mem_addr`=`12'h0A5`.
- `znc_in`=`3'b100` with JZ `16'hE010` -> next fetch 0x010; `znc_in`=`3'b000` -> next fetch PC+1; repeat JN/JC with bits 1/0.
- HLT at 5: `halted`=1, `mem_req`=0, no `en` for 20 cycles; `rst` pulse -> refetch from 0.
- JMP to `12'hFFF` holding a datapath word: executes, next fetch address `12'h000`; async `rst` asserted mid-wait clears `mem_req` same cycle.
